// File: rtl/cpcs_enc_pkg.sv
// Shared 8b/10b encoding tables, widths and disparity classification for cpcs_enc_nlane.
package cpcs_enc_pkg;

    localparam int BYTE_W = 8;
    localparam int SYM_W  = 10;

    typedef enum logic [1:0] {
        DC_NEUTRAL,
        DC_PLUS2,
        DC_MINUS2
    } disp_class_e;

    localparam logic [5:0] K28_6B  = 6'b001111;
    localparam logic [3:0] ALT7_4B = 4'b0111;

    // Tables hold the RD- form (abcdei / fghj, a first); RD+ forms are complements.
    function automatic logic [5:0] enc6(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;  default: c = 6'b101011;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] enc4(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;  3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;  3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;  default: c = 4'b1110;
        endcase
        return c;
    endfunction

    function automatic logic is_valid_k(input logic [7:0] b);
        return (b[4:0] == 5'd28) ||
               ((b[7:5] == 3'd7) && (b[4:0] inside {5'd23, 5'd27, 5'd29, 5'd30}));
    endfunction

    function automatic disp_class_e disp_class6(input logic [5:0] c);
        int ones;
        ones = $countones(c);
        return (ones == 3) ? DC_NEUTRAL : ((ones > 3) ? DC_PLUS2 : DC_MINUS2);
    endfunction

    function automatic disp_class_e disp_class4(input logic [3:0] c);
        int ones;
        ones = $countones(c);
        return (ones == 2) ? DC_NEUTRAL : ((ones > 2) ? DC_PLUS2 : DC_MINUS2);
    endfunction

endpackage

// File: rtl/cpcs_enc_lane.sv
// Combinational single-lane 8b/10b encoder: byte, K flag and entering RD in;
// symbol, leaving RD and invalid-K flag out.
module cpcs_enc_lane
    import cpcs_enc_pkg::*;
(
    input  logic [BYTE_W-1:0] data,
    input  logic              k,
    input  logic              rd_in,
    output logic [SYM_W-1:0]  sym,
    output logic              rd_out,
    output logic              k_err
);

    logic [4:0]  x;
    logic [2:0]  y;
    logic        k_ok;
    logic        rd_mid;
    logic        alt7;
    logic        inv6;
    logic        inv4;
    logic [5:0]  c6;
    logic [3:0]  c4;
    disp_class_e cls6;
    disp_class_e cls4;

    always_comb begin
        x     = data[4:0];
        y     = data[7:5];
        k_ok  = k && is_valid_k(data);
        k_err = k && !k_ok;

        c6     = (k_ok && x == 5'd28) ? K28_6B : enc6(x);
        cls6   = disp_class6(c6);
        // D.7 is balanced but still has distinct RD-/RD+ forms.
        inv6   = rd_in && (cls6 != DC_NEUTRAL || x == 5'd7);
        rd_mid = rd_in ^ (cls6 != DC_NEUTRAL);

        alt7 = (y == 3'd7) &&
               (k_ok ||
                (!rd_mid && (x inside {5'd17, 5'd18, 5'd20})) ||
                ( rd_mid && (x inside {5'd11, 5'd13, 5'd14})));
        c4   = alt7 ? ALT7_4B : enc4(y);
        cls4 = disp_class4(c4);

        // Balanced K.x.1/2/5/6 use the complement of the D form when RD is minus.
        if (k_ok && cls4 == DC_NEUTRAL && y != 3'd3) begin
            inv4 = !rd_mid;
        end else begin
            inv4 = rd_mid && (cls4 != DC_NEUTRAL || y == 3'd3);
        end

        sym    = {(inv6 ? ~c6 : c6), (inv4 ? ~c4 : c4)};
        rd_out = rd_mid ^ (cls4 != DC_NEUTRAL);
    end

endmodule

// File: rtl/cpcs_enc_nlane.sv
// Two-stage multi-lane 8b/10b encoder with chained running disparity.
// Optional disparity forcing is built when CPCS_ENC_FORCE_DISP_EN is defined.
module cpcs_enc_nlane
    import cpcs_enc_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int FORCE_DLY = 2
)
(
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [BYTE_W*LANES-1:0]  D,
    input  logic [LANES-1:0]         K,
    input  logic                     VALID_IN,
    input  logic                     FORCE_DISP,
    input  logic                     DISP_SEL,
    output logic [SYM_W*LANES-1:0]   Q,
    output logic                     VALID_OUT,
    output logic                     RD_OUT,
    output logic [LANES-1:0]         K_ERR
);

    logic [BYTE_W*LANES-1:0] d_s1_q, d_s1_d;
    logic [LANES-1:0]        k_s1_q, k_s1_d;
    logic                    vld_s1_q, vld_s1_d;
    logic [SYM_W*LANES-1:0]  q_q, q_d;
    logic [LANES-1:0]        kerr_q, kerr_d;
    logic                    vld_out_q, vld_out_d;
    logic                    rd_q, rd_d;
    logic [SYM_W*LANES-1:0]  sym;
    logic [LANES-1:0]        lane_kerr;
    logic                    rd_lane0;
    logic                    rd_last;

`ifdef CPCS_ENC_FORCE_DISP_EN
    logic [1:0] force_aln;
    logic       frc_s1_q, frc_s1_d;
    logic       sel_s1_q, sel_s1_d;

    if (FORCE_DLY == 0) begin : g_nodly
        assign force_aln = {FORCE_DISP, DISP_SEL};
    end else begin : g_dly
        logic [1:0] fdly_q [FORCE_DLY];
        logic [1:0] fdly_d [FORCE_DLY];

        always_comb begin
            fdly_d[0] = {FORCE_DISP, DISP_SEL};
            for (int i = 1; i < FORCE_DLY; i++) begin
                fdly_d[i] = fdly_q[i-1];
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int i = 0; i < FORCE_DLY; i++) begin
                    fdly_q[i] <= '0;
                end
            end else begin
                fdly_q <= fdly_d;
            end
        end

        assign force_aln = fdly_q[FORCE_DLY-1];
    end

    always_comb begin
        frc_s1_d = force_aln[1];
        sel_s1_d = force_aln[0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frc_s1_q <= 1'b0;
            sel_s1_q <= 1'b0;
        end else begin
            frc_s1_q <= frc_s1_d;
            sel_s1_q <= sel_s1_d;
        end
    end

    assign rd_lane0 = (vld_s1_q && frc_s1_q) ? sel_s1_q : rd_q;
`else
    logic unused_force;
    assign unused_force = ^{FORCE_DISP, DISP_SEL, FORCE_DLY[0]};
    assign rd_lane0     = rd_q;
`endif

    // Disparity ripples lane 0 -> LANES-1 within one cycle.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic rd_i;
        logic rd_o;
        if (gi == 0) begin : g_first
            assign rd_i = rd_lane0;
        end else begin : g_next
            assign rd_i = g_lane[gi-1].rd_o;
        end
        cpcs_enc_lane u_lane (
            .data   (d_s1_q[BYTE_W*gi +: BYTE_W]),
            .k      (k_s1_q[gi]),
            .rd_in  (rd_i),
            .sym    (sym[SYM_W*gi +: SYM_W]),
            .rd_out (rd_o),
            .k_err  (lane_kerr[gi])
        );
    end

    assign rd_last = g_lane[LANES-1].rd_o;

    always_comb begin
        d_s1_d    = D;
        k_s1_d    = K;
        vld_s1_d  = VALID_IN;
        vld_out_d = vld_s1_q;
        q_d       = q_q;
        kerr_d    = kerr_q;
        rd_d      = rd_q;
        if (vld_s1_q) begin
            q_d    = sym;
            kerr_d = lane_kerr;
            rd_d   = rd_last;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_s1_q    <= '0;
            k_s1_q    <= '0;
            vld_s1_q  <= 1'b0;
            q_q       <= '0;
            kerr_q    <= '0;
            vld_out_q <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            d_s1_q    <= d_s1_d;
            k_s1_q    <= k_s1_d;
            vld_s1_q  <= vld_s1_d;
            q_q       <= q_d;
            kerr_q    <= kerr_d;
            vld_out_q <= vld_out_d;
            rd_q      <= rd_d;
        end
    end

    assign Q         = q_q;
    assign VALID_OUT = vld_out_q;
    assign RD_OUT    = rd_q;
    assign K_ERR     = kerr_q;

endmodule

// File: tb/tb_cpcs_enc_nlane.sv
// Directed bench for cpcs_enc_nlane: one single-lane and one two-lane instance
// driven with hand-encoded 8b/10b vectors.
module tb_cpcs_enc_nlane;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [7:0]  d1;
    logic        k1, v1, f1, s1;
    logic [9:0]  q1;
    logic        vo1, rd1;
    logic [0:0]  ke1;

    logic [15:0] d2;
    logic [1:0]  k2;
    logic        v2, f2, s2;
    logic [19:0] q2;
    logic        vo2, rd2;
    logic [1:0]  ke2;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    cpcs_enc_nlane #(.LANES(1), .FORCE_DLY(0)) u1 (
        .CLK(clk), .RST_N(rst_n), .D(d1), .K(k1), .VALID_IN(v1),
        .FORCE_DISP(f1), .DISP_SEL(s1), .Q(q1), .VALID_OUT(vo1),
        .RD_OUT(rd1), .K_ERR(ke1)
    );

    cpcs_enc_nlane #(.LANES(2)) u2 (
        .CLK(clk), .RST_N(rst_n), .D(d2), .K(k2), .VALID_IN(v2),
        .FORCE_DISP(f2), .DISP_SEL(s2), .Q(q2), .VALID_OUT(vo2),
        .RD_OUT(rd2), .K_ERR(ke2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        $display("check %-14s observed %b expected %b", tag, obs, exp);
    endtask

    // One valid word on u1, outputs visible on return.
    task automatic send1(input logic [7:0] d, input logic k);
        d1 = d; k1 = k; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        tick();
    endtask

    task automatic send2(input logic [15:0] d, input logic [1:0] k);
        d2 = d; k2 = k; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        d1 = '0; k1 = 1'b0; v1 = 1'b0; f1 = 1'b0; s1 = 1'b0;
        d2 = '0; k2 = '0;   v2 = 1'b0; f2 = 1'b0; s2 = 1'b0;
        tick(); tick(); tick();
        chk("rst_q1",   32'(q1),  32'd0);
        chk("rst_vo1",  32'(vo1), 32'd0);
        chk("rst_rd1",  32'(rd1), 32'd0);
        chk("rst_ke1",  32'(ke1), 32'd0);
        chk("rst_q2",   32'(q2),  32'd0);
        chk("rst_vo2",  32'(vo2), 32'd0);
        rst_n = 1'b1;
        tick();

`ifdef CPCS_ENC_FORCE_DISP_EN
        d1 = 8'hBC; k1 = 1'b1; v1 = 1'b1; f1 = 1'b1; s1 = 1'b1;
        tick();
        v1 = 1'b0; f1 = 1'b0; s1 = 1'b0;
        tick();
        chk("frc_q",    32'(q1),  32'b1100000101);
        chk("frc_rd",   32'(rd1), 32'd0);
        f1 = 1'b1; s1 = 1'b1;
        tick();
        f1 = 1'b0; s1 = 1'b0;
        tick();
        chk("frc_idle_vo", 32'(vo1), 32'd0);
        send1(8'hBC, 1'b1);
        chk("frc_idle_q",  32'(q1),  32'b0011111010);
        send1(8'hBC, 1'b1);
        chk("frc_rest_rd", 32'(rd1), 32'd0);
`endif

        // Back-to-back K28.5 on the single lane.
        d1 = 8'hBC; k1 = 1'b1; v1 = 1'b1;
        tick();
        tick();
        chk("k285a_q",  32'(q1),  32'b0011111010);
        chk("k285a_rd", 32'(rd1), 32'd1);
        chk("k285a_vo", 32'(vo1), 32'd1);
        v1 = 1'b0;
        tick();
        chk("k285b_q",  32'(q1),  32'b1100000101);
        chk("k285b_rd", 32'(rd1), 32'd0);
        chk("k285b_vo", 32'(vo1), 32'd1);
        tick();
        chk("idle_vo",  32'(vo1), 32'd0);
        chk("idle_q",   32'(q1),  32'b1100000101);

        send1(8'h00, 1'b0);
        chk("d00_q",    32'(q1),  32'b1001110100);
        chk("d00_rd",   32'(rd1), 32'd0);
        send1(8'hB5, 1'b0);
        chk("d215n_q",  32'(q1),  32'b1010101010);
        chk("d215n_rd", 32'(rd1), 32'd0);
        send1(8'hBC, 1'b1);
        chk("k285p_rd", 32'(rd1), 32'd1);
        send1(8'hB5, 1'b0);
        chk("d215p_q",  32'(q1),  32'b1010101010);
        chk("d215p_rd", 32'(rd1), 32'd1);
        send1(8'h00, 1'b0);
        chk("d00p_q",   32'(q1),  32'b0110001011);
        chk("d00p_rd",  32'(rd1), 32'd1);
        send1(8'hBC, 1'b1);
        chk("k285n_q",  32'(q1),  32'b1100000101);

        send1(8'hF1, 1'b0);
        chk("d177_q",   32'(q1),  32'b1000110111);
        chk("d177_rd",  32'(rd1), 32'd1);
        send1(8'hBC, 1'b1);
        chk("k285c_rd", 32'(rd1), 32'd0);

        send1(8'hEB, 1'b0);
        chk("d117n_q",  32'(q1),  32'b1101001110);
        chk("d117n_rd", 32'(rd1), 32'd1);
        send1(8'hEB, 1'b0);
        chk("d117p_q",  32'(q1),  32'b1101001000);
        chk("d117p_rd", 32'(rd1), 32'd0);

        send1(8'h00, 1'b1);
        chk("kbad_q",   32'(q1),  32'b1001110100);
        chk("kbad_err", 32'(ke1), 32'd1);
        send1(8'hF7, 1'b1);
        chk("k237_q",   32'(q1),  32'b1110101000);
        chk("k237_err", 32'(ke1), 32'd0);
        chk("k237_rd",  32'(rd1), 32'd0);

        // Two-lane word: check latency is exactly two cycles.
        d2 = 16'hBCBC; k2 = 2'b11; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        chk("l2_vo_c1", 32'(vo2), 32'd0);
        tick();
        chk("l2_vo_c2", 32'(vo2), 32'd1);
        chk("l2_k285_q", 32'(q2), 32'b1100000101_0011111010);
        chk("l2_k285_rd", 32'(rd2), 32'd0);
        tick();
        chk("l2_vo_c3", 32'(vo2), 32'd0);

        send2(16'hF100, 2'b00);
        chk("l2_mix_q",  32'(q2),  32'b1000110111_1001110100);
        chk("l2_mix_rd", 32'(rd2), 32'd1);

        // Reset with words in flight.
        d2 = 16'hBCBC; k2 = 2'b11; v2 = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_q",   32'(q2),  32'd0);
        chk("mrst_vo",  32'(vo2), 32'd0);
        chk("mrst_rd",  32'(rd2), 32'd0);
        v2 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_vo",  32'(vo2), 32'd0);
        send2(16'hBCBC, 2'b11);
        chk("post_q",   32'(q2),  32'b1100000101_0011111010);
        chk("post_rd",  32'(rd2), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cpcs_enc_nlane.md
CPCS_ENC_NLANE -- requirements
Module: cpcs_enc_nlane

Interface
REQ-001 Parameter LANES, default 2, range 1..8: number of byte lanes encoded per word.
REQ-002 Parameter FORCE_DLY, default 2, range 0..4: extra cycles that FORCE_DISP/DISP_SEL are delayed so they align with data arriving late from upstream.
REQ-003 CLK  in  1  the single clock; all state changes on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 D  in  8*LANES  input bytes; lane i is D[8i+7:8i]; lane 0 is first on the wire.
REQ-006 K  in  LANES  per-lane control-character flag.
REQ-007 VALID_IN  in  1  word qualifier.
REQ-008 FORCE_DISP  in  1  force the starting disparity of lane 0.
REQ-009 DISP_SEL  in  1  forced disparity value; 0=RD-, 1=RD+.
REQ-010 Q  out  10*LANES  encoded symbols; lane i is Q[10i+9:10i], ordered abcdei fghj, with a at bit 10i+9.
REQ-011 VALID_OUT  out  1  Q qualifier.
REQ-012 RD_OUT  out  1  running disparity after the last lane of the word currently on Q.
REQ-013 K_ERR  out  LANES  per-lane flag for an invalid K code, aligned with Q.

Function
REQ-014 Latency shall be 2 cycles from VALID_IN/D/K to VALID_OUT/Q/K_ERR.
REQ-015 Stage 1 shall register D, K and VALID_IN, plus the delayed FORCE_DISP/DISP_SEL, and shall compute per-lane 5b/6b and 3b/4b candidate codes and disparity classes.
REQ-016 Stage 2 shall chain disparity through the lanes in order: lane 0 uses the registered RD; lane i uses the RD leaving lane i-1.
REQ-017 At the end of stage 2 the RD register shall be updated with the RD leaving lane LANES-1.
REQ-018 The 6b sub-block shall be selected by the entering RD; the 4b sub-block shall be selected by the RD leaving the 6b sub-block.
REQ-019 Alternate D.x.A7 (fghj) shall be used for x=17,18,20 when RD=- and for x=11,13,14 when RD=+; K.x.7 shall always use the alternate form.
REQ-020 Valid K codes are K28.0-K28.7, K23.7, K27.7, K29.7 and K30.7; any other K=1 lane shall be encoded as the D code of the same byte, with K_ERR set for that lane.
REQ-021 When the aligned force is 1 for a valid word, lane 0 shall enter with RD=DISP_SEL regardless of the RD register; the chain and RD update then proceed normally.
REQ-022 When stage-1 valid is 0: the RD register shall hold, VALID_OUT=0, Q and K_ERR shall hold their last values, and any aligned force shall be ignored.
REQ-023 Back-to-back valid words shall be accepted every cycle with no bubbles.

Reset
REQ-024 While RST_N=0: Q=0, VALID_OUT=0, K_ERR=0, RD register=0 (RD-), all pipeline and force-delay registers=0.
REQ-025 A reset asserted mid-word shall discard in-flight words; the first word after release shall start at RD-.

Configuration
REQ-026 Macro CPCS_ENC_FORCE_DISP_EN: when defined, force logic and the FORCE_DLY delay line are built per REQ-021.
REQ-027 When CPCS_ENC_FORCE_DISP_EN is undefined, FORCE_DISP and DISP_SEL remain as ports but are ignored, no delay registers are built, and lane 0 always uses the RD register.

Structure
REQ-028 Package cpcs_enc_pkg shall hold the 5b/6b and 3b/4b tables, the valid-K list, the lane and symbol width constants (8 and 10), and a disparity-class enum (neutral, plus2, minus2).
REQ-029 Sub-module cpcs_enc_lane shall be purely combinational: (byte, K, RD in) -> (10b symbol, RD out, K_ERR); it is instanced LANES times in stage 2.

Verification
REQ-030 LANES=1, RD-, K28.5, then K28.5 -> Q=0011111010, then 1100000101; RD_OUT=1, then 0.
REQ-031 LANES=1, RD-, D0.0 -> Q=1001110100, RD_OUT=0; D21.5 at either RD -> Q=1010101010, RD unchanged.
REQ-032 LANES=2, RD-, both lanes K28.5 -> lane0=0011111010, lane1=1100000101, RD_OUT=0, VALID_OUT exactly 2 cycles after VALID_IN.
REQ-033 Macro defined, FORCE_DLY=0, RD register=0, FORCE_DISP=1, DISP_SEL=1, K28.5 -> lane0=1100000101, RD_OUT=0; same word with FORCE_DISP during VALID_IN=0 -> no effect.
REQ-034 K=1, D=0x00 on lane 0 -> K_ERR[0]=1 two cycles later and Q=D0.0 code; RD-, D17.7 -> Q=1000110111, RD_OUT=1.
REQ-035 Assert RST_N low while 2 words are in flight -> VALID_OUT=0, Q=0 immediately; first word after release encoded from RD-.
